// File: rtl/posit_opgroup_vec_noncomp_slice.sv
// Lane-wise posit MIN/MAX, sign-injection and compares over a Width-bit vector.
// Latency: NumPipeRegs cycles (0 = purely combinational).
// Backpressure: valid/ready per stage; a stage accepts when empty or drained.
module posit_opgroup_vec_noncomp_slice #(
    parameter int unsigned Width       = 64,
    parameter int unsigned PositWidth  = 16,
    parameter int unsigned NumPipeRegs = 2,
    parameter int unsigned TagWidth    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0][Width-1:0] operands_i,
    input  logic [2:0]            op_i,
    input  logic                  vectorial_op_i,
    input  logic [TagWidth-1:0]   tag_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    output logic [Width-1:0]      result_o,
    output logic [4:0]            status_o,
    output logic [TagWidth-1:0]   tag_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o
);

    localparam int unsigned NumLanes = Width / PositWidth;
    localparam logic [PositWidth-1:0] NarPat = {1'b1, {(PositWidth-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MIN, OP_MAX, OP_SGNJ, OP_SGNJN, OP_SGNJX, OP_LE, OP_LT, OP_EQ
    } op_e;

    function automatic logic [PositWidth-1:0] lane_op(
        input logic [PositWidth-1:0] a,
        input logic [PositWidth-1:0] b,
        input op_e                   op
    );
        logic a_nar, b_nar, a_lt_b, a_eq_b, neg;
        a_nar  = (a == NarPat);
        b_nar  = (b == NarPat);
        a_lt_b = $signed(a) < $signed(b);
        a_eq_b = (a == b);
        neg    = (op == OP_SGNJ)  ? (a[PositWidth-1] ^ b[PositWidth-1]) :
                 (op == OP_SGNJN) ? ~(a[PositWidth-1] ^ b[PositWidth-1]) :
                                    b[PositWidth-1];
        lane_op = '0;
        case (op)
            OP_MIN:  lane_op = a_nar ? b : (b_nar ? a : (a_lt_b ? a : b));
            OP_MAX:  lane_op = a_nar ? b : (b_nar ? a : (a_lt_b ? b : a));
            OP_LE:   lane_op[0] = ~a_nar & ~b_nar & (a_lt_b | a_eq_b);
            OP_LT:   lane_op[0] = ~a_nar & ~b_nar & a_lt_b;
            OP_EQ:   lane_op[0] = a_eq_b;
            // Two's-complement negation leaves zero and NaR unchanged.
            default: lane_op = neg ? -a : a;
        endcase
        return lane_op;
    endfunction

    op_e              op_c;
    logic [Width-1:0] res_c;
    logic [4:0]       sts_c;
    logic             nv_c;

    assign op_c = op_e'(op_i);

    always_comb begin
        res_c = '0;
        nv_c  = 1'b0;
        for (int l = 0; l < int'(NumLanes); l++) begin
            if (vectorial_op_i || l == 0) begin
                res_c[l*PositWidth +: PositWidth] =
                    lane_op(operands_i[0][l*PositWidth +: PositWidth],
                            operands_i[1][l*PositWidth +: PositWidth], op_c);
                if ((operands_i[0][l*PositWidth +: PositWidth] == NarPat ||
                     operands_i[1][l*PositWidth +: PositWidth] == NarPat) &&
                    (op_c == OP_MIN || op_c == OP_MAX || op_c == OP_LE || op_c == OP_LT))
                    nv_c = 1'b1;
            end else begin
                res_c[l*PositWidth +: PositWidth] =
                    (op_c == OP_LE || op_c == OP_LT || op_c == OP_EQ) ?
                    {PositWidth{1'b0}} : {PositWidth{1'b1}};
            end
        end
        sts_c = {nv_c, 4'b0000};
    end

    logic                out_vld;
    logic [Width-1:0]    out_dat;
    logic [4:0]          out_sts;
    logic [TagWidth-1:0] out_tag;

    if (NumPipeRegs == 0) begin : g_comb
        assign in_ready_o = out_ready_i;
        assign out_vld    = in_valid_i;
        assign out_dat    = res_c;
        assign out_sts    = sts_c;
        assign out_tag    = tag_i;
        assign busy_o     = 1'b0;
    end else begin : g_pipe
        logic [NumPipeRegs-1:0]               vld_q, vld_d, rdy;
        logic [NumPipeRegs-1:0][Width-1:0]    dat_q, dat_d;
        logic [NumPipeRegs-1:0][4:0]          sts_q, sts_d;
        logic [NumPipeRegs-1:0][TagWidth-1:0] tag_q, tag_d;
        logic                                 tail_full;

        // A stage can take data unless it and every stage after it is full
        // and the output is stalled.
        always_comb begin
            tail_full = 1'b1;
            rdy       = '0;
            for (int i = int'(NumPipeRegs) - 1; i >= 0; i--) begin
                tail_full = tail_full & vld_q[i];
                rdy[i]    = out_ready_i | ~tail_full;
            end
        end

        always_comb begin
            vld_d    = '0;
            dat_d    = '0;
            sts_d    = '0;
            tag_d    = '0;
            vld_d[0] = in_valid_i;
            dat_d[0] = res_c;
            sts_d[0] = sts_c;
            tag_d[0] = tag_i;
            for (int i = 1; i < int'(NumPipeRegs); i++) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = dat_q[i-1];
                sts_d[i] = sts_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                vld_q <= '0;
                dat_q <= '0;
                sts_q <= '0;
                tag_q <= '0;
            end else begin
                for (int i = 0; i < int'(NumPipeRegs); i++) begin
                    if (flush_i)
                        vld_q[i] <= 1'b0;
                    else if (rdy[i])
                        vld_q[i] <= vld_d[i];
                    if (rdy[i] && vld_d[i]) begin
                        dat_q[i] <= dat_d[i];
                        sts_q[i] <= sts_d[i];
                        tag_q[i] <= tag_d[i];
                    end
                end
            end
        end

        assign in_ready_o = rdy[0];
        assign out_vld    = vld_q[NumPipeRegs-1];
        assign out_dat    = dat_q[NumPipeRegs-1];
        assign out_sts    = sts_q[NumPipeRegs-1];
        assign out_tag    = tag_q[NumPipeRegs-1];
        assign busy_o     = |vld_q;
    end

    assign out_valid_o = out_vld;
    assign result_o    = out_vld ? out_dat : {Width{1'b1}};
    assign status_o    = out_vld ? out_sts : 5'b00000;
    assign tag_o       = out_vld ? out_tag : {TagWidth{1'b0}};

endmodule

// File: tb/tb_posit_opgroup_vec_noncomp_slice.sv
// Bench for posit_opgroup_vec_noncomp_slice: directed vector table, stall/flush/reset
// sequences and a randomized run checked against a lane-level arithmetic model.
module tb_posit_opgroup_vec_noncomp_slice;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][63:0] operands;
    logic [2:0]       op;
    logic             vec;
    logic [3:0]       tag_in;
    logic             in_valid, in_ready, flush;
    logic [63:0]      result;
    logic [4:0]       status;
    logic [3:0]       tag_out;
    logic             out_valid, out_ready, busy;

    always #5 clk = ~clk;

    posit_opgroup_vec_noncomp_slice #(
        .Width(64), .PositWidth(16), .NumPipeRegs(2), .TagWidth(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .operands_i(operands), .op_i(op),
        .vectorial_op_i(vec), .tag_i(tag_in), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .flush_i(flush), .result_o(result),
        .status_o(status), .tag_o(tag_out), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .busy_o(busy)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  sts;
        logic [3:0]  tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [63:0] a, b;
        logic [2:0]  op;
        logic        vec;
        logic [63:0] res;
        logic [4:0]  sts;
    } vec_t;
    vec_t tbl[11];

    logic        hold_chk = 1'b0;
    logic [63:0] hold_res;
    logic [3:0]  hold_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Lane semantics from the posit rules, using plain signed integers.
    function automatic logic [68:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] o, input logic v);
        logic [63:0] r;
        logic        nv;
        r  = '0;
        nv = 1'b0;
        for (int l = 0; l < 4; l++) begin
            int ai, bi, sva, svb;
            logic an, bn, flip;
            logic [15:0] lr;
            ai  = int'(a[l*16 +: 16]);
            bi  = int'(b[l*16 +: 16]);
            sva = (ai >= 32768) ? ai - 65536 : ai;
            svb = (bi >= 32768) ? bi - 65536 : bi;
            an  = (sva == -32768);
            bn  = (svb == -32768);
            lr  = 16'h0000;
            if (l > 0 && !v) begin
                lr = (o >= 3'd5) ? 16'h0000 : 16'hFFFF;
            end else begin
                flip = 1'b0;
                case (o)
                    3'd0: lr = an ? 16'(bi) : bn ? 16'(ai) : (sva < svb ? 16'(ai) : 16'(bi));
                    3'd1: lr = an ? 16'(bi) : bn ? 16'(ai) : (sva > svb ? 16'(ai) : 16'(bi));
                    3'd5: lr = (!an && !bn && sva <= svb) ? 16'd1 : 16'd0;
                    3'd6: lr = (!an && !bn && sva < svb) ? 16'd1 : 16'd0;
                    3'd7: lr = (sva == svb) ? 16'd1 : 16'd0;
                    default: begin
                        if (o == 3'd2) flip = ((sva < 0) != (svb < 0));
                        else if (o == 3'd3) flip = ((sva < 0) == (svb < 0));
                        else flip = (svb < 0);
                        lr = flip ? 16'((65536 - ai) % 65536) : 16'(ai);
                    end
                endcase
                if ((an || bn) && (o == 3'd0 || o == 3'd1 || o == 3'd5 || o == 3'd6))
                    nv = 1'b1;
            end
            r[l*16 +: 16] = lr;
        end
        return {nv, 4'b0000, r};
    endfunction

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        for (int l = 0; l < 4; l++) begin
            case ($urandom_range(0, 3))
                0: w[l*16 +: 16] = 16'h8000;
                1: w[l*16 +: 16] = 16'h0000;
                2: w[l*16 +: 16] = 16'($urandom_range(0, 7)) - 16'd3;
                default: w[l*16 +: 16] = 16'($urandom);
            endcase
        end
        return w;
    endfunction

    // One cycle, entered and left at a negedge: drive, settle, score handshakes.
    task automatic step(input logic iv, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] o, input logic v, input logic [3:0] t,
                        input logic ordy, input logic fl, output logic acc, output logic popped);
        exp_t e;
        logic [68:0] m;
        in_valid = iv; operands[0] = a; operands[1] = b; op = o; vec = v;
        tag_in = t; out_ready = ordy; flush = fl;
        #1;
        if (hold_chk) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", result, hold_res);
            check("hold_tag", 64'(tag_out), 64'(hold_tag));
        end
        hold_chk = out_valid && !out_ready && !flush && rst_n;
        hold_res = result;
        hold_tag = tag_out;
        popped = out_valid && out_ready;
        if (popped) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output: got result %h tag %h, expected no output", result, tag_out);
            end else begin
                e = sb.pop_front();
                check("sb_result", result, e.res);
                check("sb_status", 64'(status), 64'(e.sts));
                check("sb_tag", 64'(tag_out), 64'(e.tag));
            end
        end
        acc = in_valid && in_ready && !flush && rst_n;
        if (flush || !rst_n) sb.delete();
        if (acc) begin
            m = model(a, b, o, v);
            sb.push_back('{res: m[63:0], sts: m[68:64], tag: t});
        end
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 64'(out_valid), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_result"}, result, 64'hFFFF_FFFF_FFFF_FFFF);
        check({name, "_status"}, 64'(status), 64'd0);
        check({name, "_tag"}, 64'(tag_out), 64'd0);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic acc, popped;
        int   nxt, pops;
        logic [63:0] oa[4];
        logic [63:0] ob[4];

        tbl[0]  = '{64'h8000_7FFF_0001_FFFF, 64'h0002_8000_0001_0000, 3'd0, 1'b1, 64'h0002_7FFF_0001_FFFF, 5'h10};
        tbl[1]  = '{64'h1111_2222_3333_4000, 64'h5555_6666_7777_4000, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_C000, 5'h00};
        tbl[2]  = '{64'h8000_0000_1234_8000, 64'h8000_0000_1235_8000, 3'd7, 1'b1, 64'h0001_0001_0000_0001, 5'h00};
        tbl[3]  = '{64'h8000_0000_1234_8000, 64'h8000_0000_1235_8000, 3'd6, 1'b1, 64'h0000_0000_0001_0000, 5'h10};
        tbl[4]  = '{64'h8000_7FFF_0001_FFFF, 64'h0002_8000_0001_0000, 3'd1, 1'b1, 64'h0002_7FFF_0001_0000, 5'h10};
        tbl[5]  = '{64'h4000_C000_0000_8000, 64'h8000_8000_8000_8000, 3'd4, 1'b1, 64'hC000_4000_0000_8000, 5'h00};
        tbl[6]  = '{64'h4000_C000_1234_C000, 64'h8000_0001_8000_F000, 3'd2, 1'b1, 64'hC000_4000_EDCC_C000, 5'h00};
        tbl[7]  = '{64'h8000_8000_8000_0005, 64'h0000_0000_0000_0005, 3'd5, 1'b0, 64'h0000_0000_0000_0001, 5'h00};
        tbl[8]  = '{64'h0000_0000_0000_8000, 64'h0000_0000_0000_0003, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_0003, 5'h10};
        tbl[9]  = '{64'h0000_0000_0000_8000, 64'h0000_0000_0000_0000, 3'd7, 1'b0, 64'h0000_0000_0000_0000, 5'h00};
        tbl[10] = '{64'hFFFF_0001_8001_7FFF, 64'hFFFE_0001_7FFF_8001, 3'd5, 1'b1, 64'h0000_0001_0001_0000, 5'h00};

        rst_n = 1'b0; in_valid = 1'b0; operands = '0; op = 3'd0; vec = 1'b0;
        tag_in = 4'd0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle("reset");
        @(negedge clk);

        // Directed table: exact two-cycle latency and lane results.
        for (int i = 0; i < 11; i++) begin
            operands[0] = tbl[i].a; operands[1] = tbl[i].b; op = tbl[i].op;
            vec = tbl[i].vec; tag_in = 4'(i); in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("tbl%0d_lat1_valid", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("tbl%0d_result", i), result, tbl[i].res);
            check($sformatf("tbl%0d_status", i), 64'(status), 64'(tbl[i].sts));
            check($sformatf("tbl%0d_tag", i), 64'(tag_out), 64'(i));
            @(negedge clk);
        end

        // Back-to-back inputs with output stall, then release.
        for (int k = 0; k < 4; k++) begin oa[k] = rand_word(); ob[k] = rand_word(); end
        nxt = 0;
        for (int c = 0; c < 2; c++) begin
            step(1'b1, oa[nxt], ob[nxt], 3'd0, 1'b1, 4'(8 + nxt), 1'b1, 1'b0, acc, popped);
            check("fill_accept", 64'(acc), 64'd1);
            if (acc) nxt++;
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b1, oa[nxt], ob[nxt], 3'd0, 1'b1, 4'(8 + nxt), 1'b0, 1'b0, acc, popped);
            check("stall_in_ready", 64'(acc), 64'd0);
        end
        for (int c = 0; c < 4; c++) begin
            step(nxt < 4, oa[nxt < 4 ? nxt : 3], ob[nxt < 4 ? nxt : 3], 3'd0, 1'b1,
                 4'(8 + (nxt < 4 ? nxt : 3)), 1'b1, 1'b0, acc, popped);
            check("release_pop", 64'(popped), 64'd1);
            if (acc) nxt++;
        end
        check("release_accepted", 64'(nxt), 64'd4);
        check("release_drained", 64'(sb.size()), 64'd0);

        // Flush with two in flight plus a concurrent input.
        step(1'b1, oa[0], ob[0], 3'd1, 1'b1, 4'd1, 1'b0, 1'b0, acc, popped);
        step(1'b1, oa[1], ob[1], 3'd1, 1'b1, 4'd2, 1'b0, 1'b0, acc, popped);
        step(1'b1, oa[2], ob[2], 3'd1, 1'b1, 4'd3, 1'b0, 1'b1, acc, popped);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, '0, '0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0, acc, popped);
            if (popped) pops++;
        end
        check("flush_no_output", 64'(pops), 64'd0);

        // Reset with a full pipeline.
        step(1'b1, oa[0], ob[0], 3'd2, 1'b1, 4'd5, 1'b0, 1'b0, acc, popped);
        step(1'b1, oa[1], ob[1], 3'd2, 1'b1, 4'd6, 1'b0, 1'b0, acc, popped);
        check("prereset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        step(1'b0, '0, '0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, acc, popped);
        rst_n = 1'b1;
        hold_chk = 1'b0;
        #1;
        check_idle("midreset");
        pops = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, '0, '0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0, acc, popped);
            if (popped) pops++;
        end
        check("reset_no_stale", 64'(pops), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 9) < 7, rand_word(), rand_word(), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 49) == 0, acc, popped);
        end
        for (int c = 0; c < 10; c++)
            step(1'b0, '0, '0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0, acc, popped);
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
